// File: rtl/draw_sequencer_pkg.sv
// Shared types for the sprite draw sequencer: FSM encoding, ROM image selects
// and the fixed animation frame order.
package draw_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] IMG_CENTER = 2'b01;
    localparam logic [1:0] IMG_RIGHT  = 2'b10;
    localparam logic [1:0] IMG_LEFT   = 2'b11;

    // Animation order: center, right, center, left, then repeat.
    function automatic logic [1:0] frame_image(input logic [1:0] idx);
        logic [1:0] sel;
        case (idx)
            2'd0:    sel = IMG_CENTER;
            2'd1:    sel = IMG_RIGHT;
            2'd2:    sel = IMG_CENTER;
            2'd3:    sel = IMG_LEFT;
            default: sel = IMG_CENTER;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/draw_sequencer_raster_scan_counter.sv
// Raster generator: walks x across each row and y down the drawn band while
// producing the linear sprite ROM address.
module raster_scan_counter #(
    parameter int H_PIXELS = 320,
    parameter int Y_START  = 75,
    parameter int Y_END    = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [15:0] addr,
    output logic        last
);

    localparam logic [8:0] X_LAST  = 9'(H_PIXELS - 1);
    localparam logic [7:0] Y_FIRST = 8'(Y_START);
    localparam logic [7:0] Y_LAST  = 8'(Y_END - 1);

    logic [8:0]  x_r;
    logic [7:0]  y_r;
    logic [15:0] addr_r;

    // Clear takes priority so a new frame always starts at the band origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= 9'd0;
            y_r    <= 8'd0;
            addr_r <= 16'd0;
        end else if (clear) begin
            x_r    <= 9'd0;
            y_r    <= Y_FIRST;
            addr_r <= 16'd0;
        end else if (enable) begin
            addr_r <= addr_r + 16'd1;
            if (x_r == X_LAST) begin
                x_r <= 9'd0;
                y_r <= y_r + 8'd1;
            end else begin
                x_r <= x_r + 9'd1;
            end
        end
    end

    assign x    = x_r;
    assign y    = y_r;
    assign addr = addr_r;
    assign last = (x_r == X_LAST) && (y_r == Y_LAST);

endmodule

// File: rtl/draw_sequencer.sv
// Sprite animation sequencer: rasters one ROM image per frame to the VGA
// writer, holds it on screen, then steps to the next pose until stopped.
module draw_sequencer
    import draw_sequencer_pkg::*;
#(
    parameter int H_PIXELS    = 320,
    parameter int Y_START     = 75,
    parameter int Y_END       = 240,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] rom_addr,
    output logic [1:0]  image_sel,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic        plot,
    output logic        busy,
    output logic [1:0]  frame_idx,
    output logic        frame_done
);

    localparam logic [27:0] HOLD_LAST = 28'(HOLD_CYCLES - 1);
    localparam logic [27:0] HOLD_PRE  = 28'(HOLD_CYCLES - 2);

    state_t      state_r;
    logic [27:0] hold_cnt_r;
    logic        stop_pending_r;
    logic [1:0]  frame_idx_r;
    logic [1:0]  image_sel_r;
    logic        frame_done_r;
    logic        busy_r;
    logic        plot_r;
    logic [8:0]  x_r;
    logic [7:0]  y_r;

    logic [8:0]  xcnt_s;
    logic [7:0]  ycnt_s;
    logic        last_s;
    logic        clear_s;
    logic        enable_s;
    logic        hold_last_s;
    logic [1:0]  next_idx_s;

    assign hold_last_s = (hold_cnt_r == HOLD_LAST);
    assign next_idx_s  = frame_idx_r + 2'd1;

    raster_scan_counter #(
        .H_PIXELS (H_PIXELS),
        .Y_START  (Y_START),
        .Y_END    (Y_END)
    ) u_raster (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (clear_s),
        .enable (enable_s),
        .x      (xcnt_s),
        .y      (ycnt_s),
        .addr   (rom_addr),
        .last   (last_s)
    );

    // Raster control: clear at each frame start, stop advancing on the last address.
    always_comb begin
        clear_s  = 1'b0;
        enable_s = 1'b0;
        case (state_r)
            ST_IDLE: clear_s  = start;
            ST_DRAW: enable_s = ~last_s;
            ST_HOLD: clear_s  = hold_last_s;
            default: clear_s  = 1'b0;
        endcase
    end

    // Main FSM; plot/x/y trail the counters by one cycle to line up with ROM data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            hold_cnt_r     <= 28'd0;
            stop_pending_r <= 1'b0;
            frame_idx_r    <= 2'd0;
            image_sel_r    <= IMG_CENTER;
            frame_done_r   <= 1'b0;
            busy_r         <= 1'b0;
            plot_r         <= 1'b0;
            x_r            <= 9'd0;
            y_r            <= 8'd0;
        end else begin
            plot_r       <= (state_r == ST_DRAW);
            x_r          <= xcnt_s;
            y_r          <= ycnt_s;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r        <= ST_DRAW;
                        busy_r         <= 1'b1;
                        stop_pending_r <= stop;
                    end
                end
                ST_DRAW: begin
                    stop_pending_r <= stop_pending_r | stop;
                    if (last_s) begin
                        state_r <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    stop_pending_r <= stop_pending_r | stop;
                    state_r        <= ST_HOLD;
                    hold_cnt_r     <= 28'd0;
                    frame_done_r   <= (HOLD_LAST == 28'd0);
                end
                ST_HOLD: begin
                    if (hold_last_s) begin
                        hold_cnt_r <= 28'd0;
                        if (stop_pending_r | stop) begin
                            state_r        <= ST_IDLE;
                            busy_r         <= 1'b0;
                            stop_pending_r <= 1'b0;
                            frame_idx_r    <= 2'd0;
                            image_sel_r    <= IMG_CENTER;
                        end else begin
                            state_r     <= ST_DRAW;
                            frame_idx_r <= next_idx_s;
                            image_sel_r <= frame_image(next_idx_s);
                        end
                    end else begin
                        stop_pending_r <= stop_pending_r | stop;
                        hold_cnt_r     <= hold_cnt_r + 28'd1;
                        frame_done_r   <= (hold_cnt_r == HOLD_PRE);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign image_sel  = image_sel_r;
    assign x          = x_r;
    assign y          = y_r;
    assign plot       = plot_r;
    assign busy       = busy_r;
    assign frame_idx  = frame_idx_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with a 4x2 pixel band and 3-cycle hold.
module tb_draw_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] rom_addr;
    logic [1:0]  image_sel;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        plot;
    logic        busy;
    logic [1:0]  frame_idx;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    draw_sequencer #(
        .H_PIXELS    (4),
        .Y_START     (2),
        .Y_END       (4),
        .HOLD_CYCLES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .rom_addr   (rom_addr),
        .image_sel  (image_sel),
        .x          (x),
        .y          (y),
        .plot       (plot),
        .busy       (busy),
        .frame_idx  (frame_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle k after a start: phase p=(k-1)%12, frame f=(k-1)/12; plots on p=1..8.
    function automatic logic [1:0] exp_sel(input int f);
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b10, 2'b01, 2'b11};
        return seq[f % 4];
    endfunction

    task automatic wait_idle(input string name);
        int n;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #12;
        checks++;
        if ({rom_addr, x, y, plot, image_sel, busy, frame_idx, frame_done} !==
            {16'd0, 9'd0, 8'd0, 1'b0, 2'b01, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values addr=%0d x=%0d y=%0d plot=%b sel=%b busy=%b idx=%0d done=%b",
                     rom_addr, x, y, plot, image_sel, busy, frame_idx, frame_done);
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({plot, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle plot=%b busy=%b required 0 0", plot, busy);
        end
    endtask

    task automatic test_free_run();
        int p;
        int f;
        logic exp_plot;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 61; k++) begin
            p = (k - 1) % 12;
            f = (k - 1) / 12;
            exp_plot = (p >= 1 && p <= 8);
            checks++;
            if ({plot, frame_done, busy, image_sel, frame_idx} !==
                {exp_plot, (p == 11), 1'b1, exp_sel(f), 2'(f % 4)}) begin
                errors++;
                $display("FAIL free_ctrl k=%0d plot=%b done=%b busy=%b sel=%b idx=%0d required %b %b 1 %b %0d",
                         k, plot, frame_done, busy, image_sel, frame_idx,
                         exp_plot, (p == 11), exp_sel(f), f % 4);
            end
            if (p <= 7) begin
                checks++;
                if (rom_addr !== 16'(p)) begin
                    errors++;
                    $display("FAIL free_addr k=%0d addr=%0d required %0d", k, rom_addr, p);
                end
            end
            if (exp_plot) begin
                checks++;
                if ({x, y} !== {9'((p - 1) % 4), 8'(2 + (p - 1) / 4)}) begin
                    errors++;
                    $display("FAIL free_xy k=%0d x=%0d y=%0d required %0d %0d",
                             k, x, y, (p - 1) % 4, 2 + (p - 1) / 4);
                end
            end
            if (k != 61) tick();
        end
        wait_idle("free_run");
    endtask

    task automatic test_stop_mid_frame();
        int plots;
        plots = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            stop = (k == 15);
            if (plot) plots++;
            if (k == 24) begin
                checks++;
                if ({busy, frame_done} !== 2'b11) begin
                    errors++;
                    $display("FAIL stop_last_hold busy=%b done=%b required 1 1", busy, frame_done);
                end
            end
            tick();
        end
        stop = 1'b0;
        checks++;
        if (plots !== 16) begin
            errors++;
            $display("FAIL stop_plot_count got=%0d required 16", plots);
        end
        checks++;
        if ({busy, frame_idx, image_sel} !== {1'b0, 2'd0, 2'b01}) begin
            errors++;
            $display("FAIL stop_idle busy=%b idx=%0d sel=%b required 0 0 01", busy, frame_idx, image_sel);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({plot, image_sel, frame_idx} !== {1'b1, 2'b01, 2'd0}) begin
            errors++;
            $display("FAIL restart_center plot=%b sel=%b idx=%0d required 1 01 0", plot, image_sel, frame_idx);
        end
        wait_idle("restart");
    endtask

    task automatic test_start_stop_same();
        int plots;
        int dones;
        plots = 0;
        dones = 0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (plot) plots++;
            if (frame_done) dones++;
            if (k == 12 || k == 13) begin
                checks++;
                if (busy !== (k == 12)) begin
                    errors++;
                    $display("FAIL one_shot_busy k=%0d busy=%b required %b", k, busy, (k == 12));
                end
            end
            tick();
        end
        checks++;
        if ({plots, dones} !== {32'd8, 32'd1}) begin
            errors++;
            $display("FAIL one_shot_counts plots=%0d dones=%0d required 8 1", plots, dones);
        end
    endtask

    task automatic test_reset_mid_draw();
        int plots;
        plots = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checks++;
        if ({plot, x, y} !== {1'b1, 9'd3, 8'd2}) begin
            errors++;
            $display("FAIL fourth_plot plot=%b x=%0d y=%0d required 1 3 2", plot, x, y);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({plot, x, y, busy} !== {1'b0, 9'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset plot=%b x=%0d y=%0d busy=%b required 0 0 0 0", plot, x, y, busy);
        end
        #2 reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (plot || busy) plots++;
        end
        checks++;
        if (plots !== 0) begin
            errors++;
            $display("FAIL post_reset_quiet active_cycles=%0d required 0", plots);
        end
    endtask

    task automatic test_back_to_back();
        int p;
        int f;
        logic exp_plot;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            start = (k == 3 || k == 12 || k == 16);
            p = (k - 1) % 12;
            f = (k - 1) / 12;
            exp_plot = (p >= 1 && p <= 8);
            checks++;
            if ({plot, frame_done, image_sel} !== {exp_plot, (p == 11), exp_sel(f)}) begin
                errors++;
                $display("FAIL b2b k=%0d plot=%b done=%b sel=%b required %b %b %b",
                         k, plot, frame_done, image_sel, exp_plot, (p == 11), exp_sel(f));
            end
            tick();
        end
        start = 1'b0;
        wait_idle("back_to_back");
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stop_mid_frame();
        test_start_stop_same();
        test_reset_mid_draw();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
